// File: rtl/sat_compute_unit.sv
// sat_compute_unit
// Multi-cycle compute unit sitting between issue and writeback. One operation
// is in flight at a time: it is accepted in IDLE, iterated in SHIFT or RED
// when needed, and presented in DONE until the consumer takes it.
//
// Operations (op): 0 ADD, 1 SUB (both signed, saturating), 2 PADD (lane-wise
// signed saturating add), 3 SLL, 4 SRA, 5 ROR (one bit per cycle), 6 RED
// (sum of sign-extended bytes of a then b, one byte per cycle), 7 reserved
// (result 0).
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    operation handshake (accept when both high)
//   op, a, b, shamt        operation and operands, captured at accept
//   out_valid / out_ready  result handshake (handoff when both high)
//   result, ovfl           result value and saturation flag, stable in DONE
//   sticky_ovfl            OR of ovfl since the last clr_sticky
//   clr_sticky             synchronous clear; a simultaneous set wins
module sat_compute_unit #(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     ovfl,
  output logic                     sticky_ovfl,
  input  logic                     clr_sticky
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;      // holds both WIDTH-1 and NB
  localparam int NB    = 2 * WIDTH / 8; // bytes summed by RED
  localparam int LANES = WIDTH / LANE_W;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_PADD, OP_SLL, OP_SRA, OP_ROR, OP_RED, OP_RSV
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RED, S_DONE} state_e;

  state_e             state;
  op_e                op_q;
  logic [SH_W-1:0]    shamt_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [2*WIDTH-1:0] opnd_q;   // {b, a}; RED consumes the low byte each step

  // Single-cycle arithmetic, evaluated on the live inputs and captured at accept.
  logic [WIDTH:0]     add_ext;
  logic [WIDTH-1:0]   add_res;
  logic               add_ovf;
  logic [LANE_W:0]    lane_sum;
  logic [WIDTH-1:0]   padd_res;
  logic               padd_ovf;

  assign cnt_nxt = cnt + CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    add_ext  = '0;
    add_res  = '0;
    add_ovf  = 1'b0;
    lane_sum = '0;
    padd_res = '0;
    padd_ovf = 1'b0;

    // One guard bit gives the true signed result, so 0 - MIN saturates positive.
    if (op == OP_SUB) add_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    else              add_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    add_ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
    if (add_ovf) add_res = add_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
    else         add_res = add_ext[WIDTH-1:0];

    // Each lane is sign-extended on its own, so no carry crosses a lane boundary.
    for (int i = 0; i < LANES; i++) begin
      lane_sum = {a[i*LANE_W+LANE_W-1], a[i*LANE_W +: LANE_W]}
               + {b[i*LANE_W+LANE_W-1], b[i*LANE_W +: LANE_W]};
      if (lane_sum[LANE_W] != lane_sum[LANE_W-1]) begin
        padd_ovf = 1'b1;
        padd_res[i*LANE_W +: LANE_W] = lane_sum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                                        : {1'b0, {(LANE_W-1){1'b1}}};
      end else begin
        padd_res[i*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      ovfl        <= 1'b0;
      sticky_ovfl <= 1'b0;
      op_q        <= OP_ADD;
      shamt_q     <= '0;
      cnt         <= '0;
      opnd_q      <= '0;
    end else begin
      // Clear first; a set later in this block overrides it.
      if (clr_sticky) sticky_ovfl <= 1'b0;

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= op_e'(op);
            shamt_q  <= shamt;
            opnd_q   <= {b, a};
            cnt      <= '0;
            ovfl     <= 1'b0;
            in_ready <= 1'b0;
            case (op_e'(op))
              OP_ADD, OP_SUB: begin
                result    <= add_res;
                ovfl      <= add_ovf;
                if (add_ovf) sticky_ovfl <= 1'b1;
                state     <= S_DONE;
                out_valid <= 1'b1;
              end
              OP_PADD: begin
                result    <= padd_res;
                ovfl      <= padd_ovf;
                if (padd_ovf) sticky_ovfl <= 1'b1;
                state     <= S_DONE;
                out_valid <= 1'b1;
              end
              OP_SLL, OP_SRA, OP_ROR: begin
                // result doubles as the shift register while iterating.
                result <= a;
                if (shamt == '0) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                end else begin
                  state <= S_SHIFT;
                end
              end
              OP_RED: begin
                result <= '0;
                state  <= S_RED;
              end
              default: begin
                result    <= '0;
                state     <= S_DONE;
                out_valid <= 1'b1;
              end
            endcase
          end
        end

        S_SHIFT: begin
          case (op_q)
            OP_SLL:  result <= {result[WIDTH-2:0], 1'b0};
            OP_SRA:  result <= {result[WIDTH-1], result[WIDTH-1:1]};
            default: result <= {result[0], result[WIDTH-1:1]};
          endcase
          cnt <= cnt_nxt;
          if (cnt_nxt == {1'b0, shamt_q}) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end

        S_RED: begin
          result <= result + {{(WIDTH-8){opnd_q[7]}}, opnd_q[7:0]};
          opnd_q <= opnd_q >> 8;
          cnt    <= cnt_nxt;
          if (cnt_nxt == CNT_W'(NB)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end

        default: begin  // S_DONE: result and ovfl hold until handoff
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sat_compute_unit.sv
// Self-checking bench for sat_compute_unit (WIDTH=16, LANE_W=4).
// The driver computes each expected response from an arithmetic reference
// model and queues it at accept; the monitor pops and compares at handoff.
module tb_sat_compute_unit;

  localparam int W  = 16;
  localparam int LW = 4;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [SW-1:0] shamt = '0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          ovfl;
  logic          sticky_ovfl;
  logic          clr_sticky = 1'b0;

  sat_compute_unit #(.WIDTH(W), .LANE_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .ovfl        (ovfl),
    .sticky_ovfl (sticky_ovfl),
    .clr_sticky  (clr_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    bit           ov;
    int           lat;
    int           e0;
    bit           st;
    int           opc;
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    exp_sticky = 1'b0;
  int    ready_mode = 1;  // 0 hold low, 1 hold high, 2 random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain signed integer arithmetic with clamping.
  function automatic void model(input int opc, input logic [W-1:0] av, input logic [W-1:0] bv,
                                input int sh, output logic [W-1:0] r, output bit ov,
                                output int lat);
    int s, x, y, hi, lo;
    logic [2*W-1:0] bytes;
    r = '0; ov = 1'b0; lat = 0;
    case (opc)
      0, 1: begin
        x = int'($signed(av));
        y = int'($signed(bv));
        s = (opc == 0) ? x + y : x - y;
        hi = (1 << (W-1)) - 1;
        lo = -(1 << (W-1));
        if (s > hi) begin s = hi; ov = 1'b1; end
        else if (s < lo) begin s = lo; ov = 1'b1; end
        r = s[W-1:0];
      end
      2: begin
        for (int l = 0; l < W/LW; l++) begin
          x = int'($signed(av[l*LW +: LW]));
          y = int'($signed(bv[l*LW +: LW]));
          s = x + y;
          if (s > 7) begin s = 7; ov = 1'b1; end
          else if (s < -8) begin s = -8; ov = 1'b1; end
          r[l*LW +: LW] = s[LW-1:0];
        end
      end
      3: begin r = av << sh; lat = sh; end
      4: begin r = $signed(av) >>> sh; lat = sh; end
      5: begin r = (av >> sh) | (av << (W - sh)); lat = sh; end
      6: begin
        bytes = {bv, av};
        s = 0;
        for (int k = 0; k < 2*W/8; k++) s += int'($signed(bytes[k*8 +: 8]));
        r = s[W-1:0];
        lat = 2*W/8;
      end
      default: r = '0;
    endcase
  endfunction

  // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
  task automatic issue(input int opc, input logic [W-1:0] av, input logic [W-1:0] bv, input int sh);
    item_t it;
    int    budget = 0;
    while (!in_ready) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 1000) begin
        check("issue_wait_in_ready_timeout", 32'd0, 32'd1);
        return;
      end
    end
    in_valid = 1'b1;
    op       = opc[2:0];
    a        = av;
    b        = bv;
    shamt    = sh[SW-1:0];
    model(opc, av, bv, sh, it.res, it.ov, it.lat);
    @(posedge clk); #1;
    it.e0  = cyc;
    // Set wins over a simultaneous clear.
    exp_sticky = it.ov ? 1'b1 : (clr_sticky ? 1'b0 : exp_sticky);
    it.st  = exp_sticky;
    it.opc = opc;
    sb.push_back(it);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 || !in_ready) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 2000) begin
        check("drain_timeout", 32'(sb.size()), 32'd0);
        return;
      end
    end
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  initial begin
    bit    seen = 1'b0;
    int    rise = 0;
    item_t it;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else begin
        check("in_ready_vs_outstanding", 32'(in_ready), 32'(sb.size() == 0));
        if (out_valid && !seen) begin
          seen = 1'b1;
          rise = cyc;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
          end else begin
            it = sb.pop_front();
            check($sformatf("result op%0d", it.opc), 32'(result), 32'(it.res));
            check($sformatf("ovfl op%0d", it.opc), 32'(ovfl), 32'(it.ov));
            check($sformatf("latency op%0d", it.opc), 32'(rise - it.e0), 32'(it.lat));
            check($sformatf("sticky op%0d", it.opc), 32'(sticky_ovfl), 32'(it.st));
          end
          seen = 1'b0;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int           e0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_ovfl", 32'(ovfl), 32'd0);
    check("reset_sticky", 32'(sticky_ovfl), 32'd0);
    rst = 1'b0;

    // Directed arithmetic cases
    ready_mode = 1;
    issue(0, 16'h7FFF, 16'h0001, 0);
    issue(1, 16'h0005, 16'h0003, 0);
    issue(1, 16'h8000, 16'h0001, 0);
    issue(1, 16'h0000, 16'h8000, 0);
    issue(2, 16'h8009, 16'h9009, 0);
    issue(2, 16'h7111, 16'h1111, 0);
    issue(2, 16'h1234, 16'h1111, 0);
    issue(4, 16'h8000, 16'h0000, 15);
    issue(3, 16'h0001, 16'h0000, 0);
    issue(5, 16'h0001, 16'h0000, 1);
    issue(6, 16'h7F7F, 16'h8001, 0);
    issue(7, 16'hABCD, 16'h1234, 3);
    drain();

    // Backpressure: DONE held 3 cycles, new offers ignored
    ready_mode = 0;
    @(posedge clk); #1;
    issue(0, 16'h0001, 16'h0002, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op       = 3'd1;
      a        = W'($urandom);
      b        = W'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result_stable", 32'(result), 32'h0003);
    end
    in_valid   = 1'b0;
    ready_mode = 1;
    drain();

    // clr_sticky alone, then coincident with an overflowing result
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    exp_sticky = 1'b0;
    check("sticky_cleared", 32'(sticky_ovfl), 32'd0);
    clr_sticky = 1'b1;
    issue(1, 16'h8000, 16'h7FFF, 0);
    clr_sticky = 1'b0;
    check("sticky_set_wins", 32'(sticky_ovfl), 32'd1);
    drain();

    // Reset during RED step 2
    issue(6, 16'h7F7F, 16'h8001, 0);
    e0 = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("red_still_busy", 32'(cyc - e0), 32'd2);
    rst = 1'b1;
    sb.delete();
    exp_sticky = 1'b0;
    #1;
    check("midred_rst_out_valid", 32'(out_valid), 32'd0);
    check("midred_rst_result", 32'(result), 32'd0);
    check("midred_rst_in_ready", 32'(in_ready), 32'd1);
    check("midred_rst_sticky", 32'(sticky_ovfl), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(0, 16'h1234, 16'h0001, 0);
    drain();

    // Randomized traffic with random backpressure
    ready_mode = 2;
    for (int n = 0; n < 250; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      // Bias some operands toward the saturation edges.
      if ($urandom_range(0, 3) == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
      issue(int'($urandom_range(0, 7)), ra, rb, int'($urandom_range(0, W-1)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
